// File: rtl/amadeus_mem_responder.sv
// amadeus_mem_responder: word-addressed memory responder for the accelerator's
// external memory port, with a programmable read latency and a backdoor preload port.
// Optional build macro MEM_RESP_STALL_EN adds a mem_stall input that freezes the
// response FSM while it is high.
`ifndef MEM_BANDWIDTH
`define MEM_BANDWIDTH 4
`endif
`ifndef MEM_ADDR_SIZE
`define MEM_ADDR_SIZE 32
`endif

module amadeus_mem_responder #(
    parameter int unsigned DATA_W       = `MEM_BANDWIDTH*8,
    parameter int unsigned ADDR_W       = `MEM_ADDR_SIZE,
    parameter int unsigned DEPTH_LOG2   = 12,
    parameter int unsigned READ_LATENCY = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_W-1:0]     mem_addr,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [DATA_W-1:0]     mem_write_data,
`ifdef MEM_RESP_STALL_EN
    input  logic                  mem_stall,
`endif
    output logic [DATA_W-1:0]     mem_read_data,
    output logic                  mem_valid,
    input  logic                  bd_we,
    input  logic [DEPTH_LOG2-1:0] bd_addr,
    input  logic [DATA_W-1:0]     bd_wdata,
    output logic                  busy,
    output logic                  protocol_error,
    output logic [31:0]           rd_count,
    output logic [31:0]           wr_count
);

    localparam int unsigned BYTE_SHIFT = $clog2(DATA_W/8);
    localparam int unsigned DEPTH      = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE, RWAIT, RRESP, WACK} state_t;

    state_t                state;
    logic [3:0]            lat_cnt;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic                  rd_oor;
    logic [DATA_W-1:0]     storage [DEPTH];
    logic [ADDR_W-1:0]     word_idx;
    logic                  in_range;
    logic                  stall;
    logic                  wr_fire;

`ifdef MEM_RESP_STALL_EN
    assign stall = mem_stall;
`else
    assign stall = 1'b0;
`endif

    assign word_idx = mem_addr >> BYTE_SHIFT;
    assign in_range = (word_idx >> DEPTH_LOG2) == '0;
    assign wr_fire  = (state == IDLE) && !stall && mem_write && in_range;

    // Storage: backdoor first, so a same-edge front-door write to the same word wins.
    always_ff @(posedge clk) begin
        if (bd_we)
            storage[bd_addr] <= bd_wdata;
        if (wr_fire)
            storage[word_idx[DEPTH_LOG2-1:0]] <= mem_write_data;
    end

    // Request FSM with registered response, busy, error flag and saturating counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            lat_cnt        <= '0;
            rd_idx         <= '0;
            rd_oor         <= 1'b0;
            mem_valid      <= 1'b0;
            mem_read_data  <= '0;
            busy           <= 1'b0;
            protocol_error <= 1'b0;
            rd_count       <= '0;
            wr_count       <= '0;
        end else begin
            mem_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (!stall) begin
                        if (mem_write) begin
                            if (wr_count != '1)
                                wr_count <= wr_count + 32'd1;
                            if (mem_read || !in_range)
                                protocol_error <= 1'b1;
                            state <= WACK;
                            busy  <= 1'b1;
                        end else if (mem_read) begin
                            if (rd_count != '1)
                                rd_count <= rd_count + 32'd1;
                            if (!in_range)
                                protocol_error <= 1'b1;
                            rd_idx  <= word_idx[DEPTH_LOG2-1:0];
                            rd_oor  <= !in_range;
                            lat_cnt <= 4'(READ_LATENCY - 1);
                            state   <= (READ_LATENCY == 1) ? RRESP : RWAIT;
                            busy    <= 1'b1;
                        end
                    end
                end
                RWAIT: begin
                    if (!stall) begin
                        lat_cnt <= lat_cnt - 4'd1;
                        if (lat_cnt == 4'd1)
                            state <= RRESP;
                    end
                end
                RRESP: begin
                    if (!stall) begin
                        mem_valid     <= 1'b1;
                        mem_read_data <= rd_oor ? '0 : storage[rd_idx];
                        state         <= IDLE;
                        busy          <= 1'b0;
                    end
                end
                WACK: begin
                    if (!stall) begin
                        mem_valid     <= 1'b1;
                        mem_read_data <= '0;
                        state         <= IDLE;
                        busy          <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_amadeus_mem_responder.sv
// Self-checking bench for amadeus_mem_responder (DATA_W=32, 4 KiW storage, latency 4).
module tb_amadeus_mem_responder;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] mem_addr = '0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] mem_write_data = '0;
    logic        mem_stall = 1'b0;
    logic [31:0] mem_read_data;
    logic        mem_valid;
    logic        bd_we = 1'b0;
    logic [11:0] bd_addr = '0;
    logic [31:0] bd_wdata = '0;
    logic        busy;
    logic        protocol_error;
    logic [31:0] rd_count;
    logic [31:0] wr_count;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    logic [31:0] mmem [16];
    int          m_rd = 0;
    int          m_wr = 0;
    logic        m_perr = 1'b0;

    always #5 clk = ~clk;

    amadeus_mem_responder #(
        .DATA_W(32),
        .ADDR_W(32),
        .DEPTH_LOG2(12),
        .READ_LATENCY(LAT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .mem_addr(mem_addr),
        .mem_read(mem_read),
        .mem_write(mem_write),
        .mem_write_data(mem_write_data),
`ifdef MEM_RESP_STALL_EN
        .mem_stall(mem_stall),
`endif
        .mem_read_data(mem_read_data),
        .mem_valid(mem_valid),
        .bd_we(bd_we),
        .bd_addr(bd_addr),
        .bd_wdata(bd_wdata),
        .busy(busy),
        .protocol_error(protocol_error),
        .rd_count(rd_count),
        .wr_count(wr_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request held until mem_valid; optional backdoor write after the
    // bd_cyc-th edge (0 = at the acceptance edge) and stall window [s_from, s_to].
    task automatic run_op(input string tag, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] data,
                          input int bd_cyc, input logic [11:0] bda, input logic [31:0] bdd,
                          input int s_from, input int s_to, input int extra_lat);
        int          n;
        bit          got;
        int unsigned idx;
        bit          inr;
        logic [31:0] exp_data;
        int          exp_lat;

        idx = addr >> 2;
        inr = idx < 4096;
        if (bd_cyc >= 0)
            mmem[bda] = bdd;
        if (wr) begin
            if (inr) mmem[idx] = data;
            m_wr++;
            if (rd || !inr) m_perr = 1'b1;
            exp_data = 32'h0;
            exp_lat  = 1 + extra_lat;
        end else begin
            m_rd++;
            if (!inr) m_perr = 1'b1;
            exp_data = inr ? mmem[idx] : 32'h0;
            exp_lat  = LAT + extra_lat;
        end

        mem_read = rd; mem_write = wr; mem_addr = addr; mem_write_data = data;
        if (bd_cyc == 0) begin bd_we = 1'b1; bd_addr = bda; bd_wdata = bdd; end
        n = 0; got = 0;
        while (n < 40 && !got) begin
            @(posedge clk); #1;
            n++;
            bd_we = 1'b0;
            if (bd_cyc == n) begin bd_we = 1'b1; bd_addr = bda; bd_wdata = bdd; end
            mem_stall = (n >= s_from && n <= s_to);
            if (n == 1) chk({tag, ".busy"}, 64'(busy), 64'(1));
            if (mem_valid) got = 1;
        end
        bd_we = 1'b0; mem_stall = 1'b0;
        chk({tag, ".lat"}, 64'(got ? n - 1 : -1), 64'(exp_lat));
        chk({tag, ".data"}, 64'(mem_read_data), 64'(exp_data));
        chk({tag, ".rdcnt"}, 64'(rd_count), 64'(m_rd));
        chk({tag, ".wrcnt"}, 64'(wr_count), 64'(m_wr));
        chk({tag, ".perr"}, 64'(protocol_error), 64'(m_perr));
        mem_read = 1'b0; mem_write = 1'b0;
        @(posedge clk); #1;
        chk({tag, ".pulse1"}, 64'(mem_valid), 64'(0));
        chk({tag, ".idle"}, 64'(busy), 64'(0));
    endtask

    initial begin
        bit          saw_valid;
        int          r;
        int unsigned widx;
        logic [31:0] a;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst.valid", 64'(mem_valid), 64'(0));
        chk("rst.data", 64'(mem_read_data), 64'(0));
        chk("rst.busy", 64'(busy), 64'(0));
        chk("rst.perr", 64'(protocol_error), 64'(0));
        chk("rst.rd", 64'(rd_count), 64'(0));
        chk("rst.wr", 64'(wr_count), 64'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // backdoor preload of words 0..15
        for (int i = 0; i < 16; i++) begin
            bd_we = 1'b1; bd_addr = 12'(i);
            bd_wdata = (i == 5) ? 32'hA5A5_A5A5 : $urandom;
            mmem[i] = bd_wdata;
            @(posedge clk); #1;
        end
        bd_we = 1'b0;

        run_op("bdread5", 1, 0, 32'd20, 32'h0, -1, 12'd0, 32'h0, 0, -1, 0);
        run_op("wr0", 0, 1, 32'd0, 32'h1234, -1, 12'd0, 32'h0, 0, -1, 0);
        run_op("rd0", 1, 0, 32'd0, 32'h0, -1, 12'd0, 32'h0, 0, -1, 0);
        run_op("both8", 1, 1, 32'd8, 32'hBEEF_0008, -1, 12'd0, 32'h0, 0, -1, 0);
        run_op("rd8", 1, 0, 32'd8, 32'h0, -1, 12'd0, 32'h0, 0, -1, 0);
        run_op("oor_rd", 1, 0, 32'd16384, 32'h0, -1, 12'd0, 32'h0, 0, -1, 0);
        run_op("oor_wr", 0, 1, 32'd16388, 32'hDEAD_BEEF, -1, 12'd0, 32'h0, 0, -1, 0);
        run_op("bd_rwait", 1, 0, 32'd28, 32'h0, 2, 12'd7, 32'h7777_0007, 0, -1, 0);
        run_op("bd_coll", 0, 1, 32'd36, 32'hF00D_0009, 0, 12'd9, 32'h0BAD_0009, 0, -1, 0);
        run_op("rd9", 1, 0, 32'd36, 32'h0, -1, 12'd0, 32'h0, 0, -1, 0);
`ifdef MEM_RESP_STALL_EN
        run_op("stall_rd", 1, 0, 32'd12, 32'h0, -1, 12'd0, 32'h0, 1, 3, 3);
`endif

        // randomized traffic against the model
        for (int t = 0; t < 40; t++) begin
            r = $urandom_range(0, 9);
            widx = ($urandom_range(0, 7) == 0) ? 4096 + $urandom_range(0, 100) : $urandom_range(0, 15);
            a = (widx << 2) | $urandom_range(0, 3);
            if (r <= 4)
                run_op("rnd_rd", 1, 0, a, 32'h0,
                       ($urandom_range(0, 1) == 1) ? $urandom_range(0, LAT - 1) : -1,
                       12'($urandom_range(0, 15)), $urandom, 0, -1, 0);
            else if (r <= 7)
                run_op("rnd_wr", 0, 1, a, $urandom,
                       ($urandom_range(0, 1) == 1) ? 0 : -1,
                       12'($urandom_range(0, 15)), $urandom, 0, -1, 0);
            else if (r == 8)
                run_op("rnd_both", 1, 1, a, $urandom, -1, 12'd0, 32'h0, 0, -1, 0);
            else begin
                @(posedge clk); #1;
                chk("rnd_idle", 64'(mem_valid), 64'(0));
            end
        end

        // reset in the middle of RWAIT
        mem_read = 1'b1; mem_addr = 32'd12;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid.busy_pre", 64'(busy), 64'(1));
        rst_n = 1'b0; mem_read = 1'b0;
        #1;
        chk("mid.valid", 64'(mem_valid), 64'(0));
        chk("mid.data", 64'(mem_read_data), 64'(0));
        chk("mid.busy", 64'(busy), 64'(0));
        chk("mid.perr", 64'(protocol_error), 64'(0));
        chk("mid.rd", 64'(rd_count), 64'(0));
        chk("mid.wr", 64'(wr_count), 64'(0));
        saw_valid = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (mem_valid) saw_valid = 1;
        end
        rst_n = 1'b1;
        repeat (8) begin
            @(posedge clk); #1;
            if (mem_valid) saw_valid = 1;
        end
        chk("mid.nopulse", 64'(saw_valid), 64'(0));
        chk("mid.busy_post", 64'(busy), 64'(0));
        m_rd = 0; m_wr = 0; m_perr = 1'b0;
        run_op("post_rst", 1, 0, 32'd12, 32'h0, -1, 12'd0, 32'h0, 0, -1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
